// File: rtl/gate_timing_meas.sv
// gate_timing_meas: measures the delay from a trigger rising edge to the next
// rising edge of a gate signal, and the gate's high width, in clock cycles.
// Ports: Clk, Rst_n (async active-low) | Trig, Sig async inputs |
// Timeout abort limit (0 = off) | DelayOut, WidthOut, Sat result qualified
// by the Valid strobe | TimedOut abort strobe | Busy while measuring.
module gate_timing_meas #(
    parameter int N = 32
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Trig,
    input  logic         Sig,
    input  logic [N-1:0] Timeout,
    output logic [N-1:0] DelayOut,
    output logic [N-1:0] WidthOut,
    output logic         Valid,
    output logic         Sat,
    output logic         TimedOut,
    output logic         Busy
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH,
        REARM
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic         trig_s1_q, trig_s1_d;
    logic         trig_s2_q, trig_s2_d;
    logic         trig_prev_q, trig_prev_d;
    logic         sig_s1_q, sig_s1_d;
    logic         sig_s2_q, sig_s2_d;
    logic         sig_prev_q, sig_prev_d;
    state_t       state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic         sat_q, sat_d;
    logic [N-1:0] dly_q, dly_d;
    logic [N-1:0] delay_out_q, delay_out_d;
    logic [N-1:0] width_out_q, width_out_d;
    logic         sat_out_q, sat_out_d;
    logic         valid_q, valid_d;
    logic         timed_out_q, timed_out_d;

    logic         trig_rise;
    logic         sig_rise;
    logic         sig_fall;
    logic         cnt_max;
    logic [N-1:0] cnt_inc;
    logic         tmo_hit;

    assign trig_rise = trig_s2_q & ~trig_prev_q;
    assign sig_rise  = sig_s2_q & ~sig_prev_q;
    assign sig_fall  = ~sig_s2_q & sig_prev_q;
    assign cnt_max   = &cnt_q;
    // Saturate instead of wrapping; a held count is flagged through sat.
    assign cnt_inc   = cnt_max ? cnt_q : cnt_q + ONE;
    assign tmo_hit   = (Timeout != '0) && (cnt_q == Timeout);

    always_comb begin
        trig_s1_d   = Trig;
        trig_s2_d   = trig_s1_q;
        trig_prev_d = trig_s2_q;
        sig_s1_d    = Sig;
        sig_s2_d    = sig_s1_q;
        sig_prev_d  = sig_s2_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        dly_d       = dly_q;
        delay_out_d = delay_out_q;
        width_out_d = width_out_q;
        sat_out_d   = sat_out_q;
        valid_d     = 1'b0;
        timed_out_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    cnt_d = ONE;
                    sat_d = 1'b0;
                    if (sig_rise) begin
                        dly_d   = '0;
                        state_d = HIGH;
                    end else begin
                        state_d = ARM;
                    end
                end
            end
            ARM: begin
                // A real edge takes priority over a coincident timeout.
                if (sig_rise) begin
                    dly_d   = cnt_q;
                    cnt_d   = ONE;
                    state_d = HIGH;
                end else if (tmo_hit) begin
                    timed_out_d = 1'b1;
                    state_d     = REARM;
                end else begin
                    cnt_d = cnt_inc;
                    sat_d = sat_q | cnt_max;
                end
            end
            HIGH: begin
                if (sig_fall) begin
                    width_out_d = cnt_q;
                    delay_out_d = dly_q;
                    sat_out_d   = sat_q;
                    valid_d     = 1'b1;
                    state_d     = REARM;
                end else if (tmo_hit) begin
                    timed_out_d = 1'b1;
                    state_d     = REARM;
                end else begin
                    cnt_d = cnt_inc;
                    sat_d = sat_q | cnt_max;
                end
            end
            REARM: begin
                // Wait for the trigger to drop: one result per pulse.
                if (!trig_s2_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            trig_s1_q   <= 1'b0;
            trig_s2_q   <= 1'b0;
            trig_prev_q <= 1'b0;
            sig_s1_q    <= 1'b0;
            sig_s2_q    <= 1'b0;
            sig_prev_q  <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            dly_q       <= '0;
            delay_out_q <= '0;
            width_out_q <= '0;
            sat_out_q   <= 1'b0;
            valid_q     <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            trig_s1_q   <= trig_s1_d;
            trig_s2_q   <= trig_s2_d;
            trig_prev_q <= trig_prev_d;
            sig_s1_q    <= sig_s1_d;
            sig_s2_q    <= sig_s2_d;
            sig_prev_q  <= sig_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            dly_q       <= dly_d;
            delay_out_q <= delay_out_d;
            width_out_q <= width_out_d;
            sat_out_q   <= sat_out_d;
            valid_q     <= valid_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign DelayOut = delay_out_q;
    assign WidthOut = width_out_q;
    assign Sat      = sat_out_q;
    assign Valid    = valid_q;
    assign TimedOut = timed_out_q;
    assign Busy     = (state_q == ARM) || (state_q == HIGH);

endmodule

// File: tb/tb_gate_timing_meas.sv
// tb_gate_timing_meas: pin waveforms are analysed by a trace model that
// queues expected results; a monitor checks every Valid/TimedOut strobe.
module tb_gate_timing_meas;

    localparam int N    = 8;
    localparam int MAXV = (1 << N) - 1;

    logic         Clk   = 1'b0;
    logic         Rst_n = 1'b1;
    logic         Trig  = 1'b0;
    logic         Sig   = 1'b0;
    logic [N-1:0] Timeout = '0;
    logic [N-1:0] DelayOut;
    logic [N-1:0] WidthOut;
    logic         Valid;
    logic         Sat;
    logic         TimedOut;
    logic         Busy;

    typedef struct {
        bit     tmo;
        longint t;
        longint d;
        longint w;
        bit     s;
    } exp_t;

    exp_t   sbq[$];
    exp_t   got;
    int     total = 0;
    int     bad   = 0;
    bit     tr[$];
    bit     sg[$];
    bit     bexp[$];
    longint last_d = 0;
    longint last_w = 0;
    bit     last_s = 1'b0;

    gate_timing_meas #(.N(N)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Trig     (Trig),
        .Sig      (Sig),
        .Timeout  (Timeout),
        .DelayOut (DelayOut),
        .WidthOut (WidthOut),
        .Valid    (Valid),
        .Sat      (Sat),
        .TimedOut (TimedOut),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, want, $time);
        end
    endtask

    function automatic bit tval(input int i);
        return (i < 0 || i >= tr.size()) ? 1'b0 : tr[i];
    endfunction

    function automatic bit sval(input int i);
        return (i < 0 || i >= sg.size()) ? 1'b0 : sg[i];
    endfunction

    function automatic bit t_rise(input int i);
        return tval(i) && !tval(i - 1);
    endfunction

    function automatic bit s_rise(input int i);
        return sval(i) && !sval(i - 1);
    endfunction

    function automatic bit s_fall(input int i);
        return !sval(i) && sval(i - 1);
    endfunction

    function automatic longint clip(input int k);
        return (k > MAXV) ? longint'(MAXV) : longint'(k);
    endfunction

    // Walks the pin trace: index i is the pin value during cycle i. Results
    // appear 3 cycles after the pin event; Busy is high from t0+3 to e+2.
    task automatic model(input int tl, input longint base, output bit busy_end);
        int     len;
        int     pos;
        int     t0;
        int     t1;
        int     e;
        bit     to;
        longint d;
        longint w;
        bit     s;
        exp_t   x;
        len = tr.size();
        pos = 0;
        busy_end = 1'b0;
        bexp.delete();
        for (int i = 0; i < len + 3; i++) bexp.push_back(1'b0);
        while (pos < len && !busy_end) begin
            t0 = -1;
            for (int i = pos; i < len; i++) begin
                if (t_rise(i)) begin
                    t0 = i;
                    break;
                end
            end
            if (t0 < 0) break;
            t1 = -1; e = -1; to = 1'b0; d = 0; w = 0; s = 1'b0;
            if (s_rise(t0)) begin
                t1 = t0;
            end else begin
                for (int k = 1; t0 + k < len; k++) begin
                    if (s_rise(t0 + k)) begin
                        t1 = t0 + k; d = clip(k); s = (k > MAXV);
                        break;
                    end
                    if (tl != 0 && clip(k) == longint'(tl)) begin
                        to = 1'b1; e = t0 + k;
                        break;
                    end
                end
            end
            if (t1 >= 0) begin
                for (int k = 1; t1 + k < len; k++) begin
                    if (s_fall(t1 + k)) begin
                        w = clip(k); s = s | (k > MAXV); e = t1 + k;
                        break;
                    end
                    if (tl != 0 && clip(k) == longint'(tl)) begin
                        to = 1'b1; e = t1 + k;
                        break;
                    end
                end
            end
            if (e < 0) begin
                for (int m = t0 + 3; m < len + 3; m++) bexp[m] = 1'b1;
                busy_end = 1'b1;
            end else begin
                for (int m = t0 + 3; m <= e + 2; m++) bexp[m] = 1'b1;
                if (!to) begin
                    last_d = d; last_w = w; last_s = s;
                end
                x.tmo = to;
                x.t   = base + 10 * longint'(e + 3);
                x.d   = last_d;
                x.w   = last_w;
                x.s   = last_s;
                sbq.push_back(x);
                pos = e + 1;
                while (pos < len && tval(pos)) pos++;
                pos = pos + 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        Trig  = 1'b0;
        Sig   = 1'b0;
        #1;
        chk("rst_delay", DelayOut, 0);
        chk("rst_width", WidthOut, 0);
        chk("rst_valid", Valid, 0);
        chk("rst_sat", Sat, 0);
        chk("rst_tmo", TimedOut, 0);
        chk("rst_busy", Busy, 0);
        repeat (2) @(negedge Clk);
        Rst_n  = 1'b1;
        last_d = 0;
        last_w = 0;
        last_s = 1'b0;
    endtask

    task automatic clear(input int len);
        tr.delete();
        sg.delete();
        for (int i = 0; i < len; i++) begin
            tr.push_back(1'b0);
            sg.push_back(1'b0);
        end
    endtask

    task automatic set_t(input int a, input int b);
        for (int i = a; i < b; i++) tr[i] = 1'b1;
    endtask

    task automatic set_s(input int a, input int b);
        for (int i = a; i < b; i++) sg[i] = 1'b1;
    endtask

    task automatic run_trace(input int tl);
        bit     be;
        longint base;
        @(negedge Clk);
        base    = $time;
        Timeout = tl[N-1:0];
        model(tl, base, be);
        for (int m = 0; m < tr.size(); m++) begin
            if (m > 0) @(negedge Clk);
            chk("busy", Busy, bexp[m]);
            Trig = tr[m];
            Sig  = sg[m];
        end
        if (be) do_reset();
    endtask

    always @(negedge Clk) begin
        if (Rst_n && (Valid || TimedOut)) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious: valid=%0d timedout=%0d, expected none at t=%0t",
                         Valid, TimedOut, $time);
            end else begin
                got = sbq.pop_front();
                chk("kind_tmo", TimedOut, got.tmo);
                chk("kind_valid", Valid, !got.tmo);
                chk("when", $time, got.t);
                chk("delay", DelayOut, got.d);
                chk("width", WidthOut, got.w);
                chk("sat", Sat, got.s);
            end
        end
    end

    initial begin
        bit lvl;
        int la;
        int i;
        int run;
        do_reset();
        clear(80); set_t(2, 20); set_s(12, 37);
        run_trace(0);
        clear(30); set_t(3, 8); set_s(3, 4);
        run_trace(0);
        clear(90); set_t(2, 12);
        run_trace(50);
        clear(330); set_t(2, 10); set_s(5, 305);
        run_trace(0);
        clear(40); set_s(0, 5); set_s(10, 14); set_t(3, 9);
        run_trace(0);
        clear(90);
        set_t(2, 5); set_t(8, 10); set_t(14, 40); set_t(50, 90);
        set_s(12, 30); set_s(45, 48); set_s(55, 90);
        run_trace(0);
        repeat (30) begin
            la = int'($urandom_range(110, 20));
            clear(la + 70);
            i = 0; lvl = 1'b0;
            while (i < la) begin
                run = lvl ? int'($urandom_range(30, 1)) : int'($urandom_range(10, 1));
                for (int j = 0; j < run && i < la; j++) begin
                    tr[i] = lvl;
                    i++;
                end
                lvl = !lvl;
            end
            i = 0; lvl = 1'b0;
            while (i < la) begin
                run = int'($urandom_range(40, 1));
                for (int j = 0; j < run && i < la; j++) begin
                    sg[i] = lvl;
                    i++;
                end
                lvl = !lvl;
            end
            run_trace(int'($urandom_range(60, 1)));
        end
        repeat (10) @(negedge Clk);
        chk("drain", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_timing_meas.md
# gate_timing_meas

Measures the timing of a gate pulse against its trigger: the delay in clock cycles from a trigger rising edge to the next rising edge of a measured signal, and that signal's high width. It is the receive-side counterpart of the fast gate/delay generator. It sits on the FOFB timing fabric, either looped back on a generated gate for self-check or on an external timing input, and it reports one result per trigger to the register interface.

## Interface
Parameters:
- N, 32, width of the delay, width and timeout counters.

Ports:
- Clk, input, 1, sole clock; all logic is rising-edge.
- Rst_n, input, 1, asynchronous active-low reset.
- Trig, input, 1, asynchronous reference trigger. Its rising edge starts a measurement.
- Sig, input, 1, asynchronous measured gate.
- Timeout, input, N, abort limit in cycles. 0 disables the timeout. Quasi-static.
- DelayOut, output, N, last measured delay (t1-t0). Updated only with Valid.
- WidthOut, output, N, last measured width (t2-t1). Updated only with Valid.
- Valid, output, 1, one-cycle strobe when a new result is available.
- Sat, output, 1, qualifies the current result: 1 when either counter saturated. Updated with Valid.
- TimedOut, output, 1, one-cycle strobe when a measurement aborts.
- Busy, output, 1, high in states ARM and HIGH.

## Operation
- Trig and Sig each pass through a two-flop synchronizer, then one edge-detect register. All three flops reset to 0.
- A level already high at reset release is therefore seen as a rising edge. This is intentional.
- Rise means sync=1 and prev=0. Fall means sync=0 and prev=1.
- Cycle definitions:
  - t0: cycle Trig rise is detected.
  - t1: cycle Sig rise is detected.
  - t2: cycle Sig fall is detected.
- One counter, cnt (N bits), serves both phases. It saturates at all-ones and never wraps. A sat flag is set when cnt saturates.
- State machine: IDLE, ARM, HIGH, REARM.
- IDLE:
  - On Trig rise: cnt<=1, sat<=0, go to ARM.
  - If Sig rise occurs in the same cycle: latch delay=0, cnt<=1, go to HIGH.
- ARM (waiting for Sig rise):
  - On Sig rise: latch delay<=cnt, cnt<=1, go to HIGH.
  - Otherwise cnt increments.
  - Sig already high at t0 produces no rise, so the block waits for the next rise.
- HIGH (waiting for Sig fall):
  - On Sig fall: WidthOut<=cnt, DelayOut<=latched delay, Sat<=sat, Valid=1 next cycle, go to REARM.
  - Otherwise cnt increments.
- Timeout:
  - Applies in ARM or HIGH when Timeout!=0 and cnt==Timeout with no qualifying edge in that cycle.
  - Action: TimedOut=1 for one cycle, go to REARM.
  - DelayOut, WidthOut and Sat are not changed.
  - An edge in the same cycle as the timeout match wins over the timeout.
- REARM: stay until synchronized Trig is 0, then go to IDLE. This gives one result per trigger pulse.
- Trig rises while in ARM, HIGH or REARM are ignored. They do not restart the measurement.
- Rst_n low at any time, including mid-measurement:
  - Immediately: state=IDLE, cnt=0, DelayOut=0, WidthOut=0, Valid=0, Sat=0, TimedOut=0, Busy=0.
  - No partial result is ever reported.

## Timing
- Pin-to-detection latency is 3 cycles, identical for Trig and Sig, so measured differences equal pin differences (±1 cycle from synchronizer sampling).
- A 1-cycle-wide Sig pulse measures WidthOut=1.
- Sig rising in the same detected cycle as Trig gives DelayOut=0.
- Valid is asserted in cycle t2+1. DelayOut, WidthOut and Sat are stable from that cycle until the next Valid or reset.
- Busy goes high in cycle t0+1 and low in the cycle after leaving HIGH.
- TimedOut is asserted in the cycle after the match.
- The earliest next measurement is a Trig rise detected 1 cycle after synchronized Trig is seen low in REARM.

## Test plan
- Reset, then Trig rise; Sig rises 10 cycles later and stays high 25 cycles → Valid once; DelayOut=10, WidthOut=25, Sat=0.
- Trig and Sig rise on the same Clk edge; Sig high 1 cycle → DelayOut=0, WidthOut=1.
- Timeout=50; Trig rise, no Sig edge → TimedOut strobe 51 cycles after t0; previous DelayOut/WidthOut unchanged; no Valid.
- N=8, Timeout=0; Sig high 300 cycles → WidthOut=255, Sat=1.
- Sig already high at Trig rise; Sig falls, then rises 7 cycles after t0, then stays high 4 cycles → DelayOut=7, WidthOut=4.
- Extra Trig pulses during HIGH, Trig held high past t2, then assert Rst_n mid-HIGH on a second measurement:
  - First measurement gives one Valid only.
  - No new measurement starts until Trig goes low.
  - Reset zeroes all outputs; no Valid follows.
